alu_mdu: RTL and testbench

- Parametrised successor of the pipeline's single-cycle ALU for the EX stage.
- Keeps the combinational ops (add, sub, and, or, slt) at WIDTH bits and adds xor, nor and signed slt.
- Adds an iterative unsigned multiply/divide unit that writes HI/LO registers over WIDTH cycles, with a start/busy/done handshake the hazard unit uses to stall.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mdu_if.sv | 25 ++
 rtl/mdu_iter.sv | 124 ++++++++++++
 rtl/alu_mdu.sv | 56 +++++
 tb/tb_alu_mdu.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and its iterative multiply/divide unit.
// Opcode constants, MDU FSM state encoding and an opcode classifier.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operand/result bundle between the EX stage and alu_mdu.
// The pipeline side is the master; the ALU/MDU is the slave.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic             start;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;

  modport master (
    output A, B, ALUOp, start,
    input  ALUResult, HI, LO, busy, done
  );

  modport slave (
    input  A, B, ALUOp, start,
    output ALUResult, HI, LO, busy, done
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// HI/LO are loaded only on the completion edge, so partial results never leak out.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // MULT: {partial product, remaining multiplier}. DIV: low half is dividend/quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               launch;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Magnitude compare rather than sign of the difference keeps B==0 well defined.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign rem_next  = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
  assign quo_next  = {acc_q[WIDTH-2:0], div_ge};

  assign launch = start_i && is_mdu_op(op_i);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (launch) begin
          state_d  = S_RUN;
          cnt_d    = CNT_W'(WIDTH - 1);
          is_div_d = (op_i == ALU_DIV);
          b_d      = b_i;
          acc_d    = {{WIDTH{1'b0}}, a_i};
          rem_d    = '0;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d[WIDTH-1:0] = quo_next;
          rem_d            = rem_next[WIDTH-1:0];
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (is_div_q) begin
            hi_d = rem_next[WIDTH-1:0];
            lo_d = quo_next;
          end else begin
            hi_d = mul_next[2*WIDTH-1:WIDTH];
            lo_d = mul_next[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU: single-cycle logic/arithmetic ops plus HI/LO moves from the
// iterative multiply/divide unit, whose busy/done feed the hazard unit.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_mdu_if.slave bus
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mdu (
    .clk     (clk),
    .rst_n   (rst),
    .start_i (bus.start),
    .op_i    (bus.ALUOp),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .hi_o    (hi),
    .lo_o    (lo),
    .busy_o  (bus.busy),
    .done_o  (bus.done)
  );

  // MULT, DIV and reserved codes fall through to zero.
  always_comb begin
    result = '0;
    case (bus.ALUOp)
      ALU_ADD:  result = bus.A + bus.B;
      ALU_SUB:  result = bus.A - bus.B;
      ALU_AND:  result = bus.A & bus.B;
      ALU_OR:   result = bus.A | bus.B;
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_XOR:  result = bus.A ^ bus.B;
      ALU_NOR:  result = ~(bus.A | bus.B);
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
      default:  result = '0;
    endcase
  end

  assign bus.ALUResult = result;
  assign bus.HI        = hi;
  assign bus.LO        = lo;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed vectors on a 32-bit and an 8-bit instance,
// with per-instance monitors popping expected HI/LO and checking busy length on done.
module tb_alu_mdu;
  import alu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t q32[$];
  exp_t q8[$];

  alu_mdu_if #(.WIDTH(32)) bus32 ();
  alu_mdu_if #(.WIDTH(8))  bus8 ();

  alu_mdu #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  alu_mdu #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitors: pop on every done, compare HI/LO and the busy run that preceded it.
  initial begin
    int busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
      end else if (bus32.done) begin
        check("w32_done_has_pending", 64'(q32.size() > 0), 64'd1);
        if (q32.size() > 0) begin
          e = q32.pop_front();
          check({e.name, "_hi"}, 64'(bus32.HI), 64'(e.hi));
          check({e.name, "_lo"}, 64'(bus32.LO), 64'(e.lo));
          check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        end
        busy_cnt = 0;
      end else if (bus32.busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  initial begin
    int busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
      end else if (bus8.done) begin
        check("w8_done_has_pending", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          check({e.name, "_hi"}, 64'(bus8.HI), 64'(e.hi));
          check({e.name, "_lo"}, 64'(bus8.LO), 64'(e.lo));
          check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
        end
        busy_cnt = 0;
      end else if (bus8.busy) begin
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  task automatic comb32(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    bus32.A     = a;
    bus32.B     = b;
    bus32.ALUOp = op;
    #1;
    check(nm, 64'(bus32.ALUResult), 64'(exp));
  endtask

  // Drives start for exactly one rising edge; push=0 for ops that must never complete.
  task automatic issue32(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input bit push);
    exp_t e;
    bus32.A     = a;
    bus32.B     = b;
    bus32.ALUOp = op;
    bus32.start = 1'b1;
    if (push) begin
      e.name = nm;
      e.hi   = hi;
      e.lo   = lo;
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
  endtask

  task automatic issue8(input string nm, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] hi, input logic [7:0] lo);
    exp_t e;
    bus8.A     = a;
    bus8.B     = b;
    bus8.ALUOp = op;
    bus8.start = 1'b1;
    e.name = nm;
    e.hi   = 32'(hi);
    e.lo   = 32'(lo);
    q8.push_back(e);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0 || bus32.busy || bus8.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_completes"}, 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    bus32.A     = '0;
    bus32.B     = '0;
    bus32.ALUOp = ALU_ADD;
    bus32.start = 1'b0;
    bus8.A      = '0;
    bus8.B      = '0;
    bus8.ALUOp  = ALU_ADD;
    bus8.start  = 1'b0;

    #1;
    check("reset_busy", 64'(bus32.busy), 64'd0);
    check("reset_done", 64'(bus32.done), 64'd0);
    check("reset_hi",   64'(bus32.HI),   64'd0);
    check("reset_lo",   64'(bus32.LO),   64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    comb32("add_wrap",   ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    comb32("sub_wrap",   ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    comb32("sltu_neg1",  ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    comb32("slt_neg1",   ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    comb32("sltu_small", ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001);
    comb32("xor",        ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    comb32("nor",        ALU_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
    comb32("and",        ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    comb32("or",         ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    comb32("reserved",   4'b1100,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000);
    comb32("mult_code",  ALU_MULT, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000);
    check("no_start_idle", 64'(bus32.busy), 64'd0);

    issue32("mult_max", ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    check("mult_busy_first_cycle", 64'(bus32.busy), 64'd1);
    bus32.ALUOp = ALU_ADD;
    wait_idle("mult_max");
    comb32("mfhi_after_mult", ALU_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFE);
    comb32("mflo_after_mult", ALU_MFLO, 32'h0, 32'h0, 32'h0000_0001);

    issue32("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1);
    wait_idle("div_100_7");
    issue32("div_by_zero", ALU_DIV, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    wait_idle("div_by_zero");

    // MULT 3*5 with a DIV start and operand churn in RUN cycle 10.
    issue32("mult_3_5", ALU_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    comb32("mfhi_while_busy", ALU_MFHI, 32'd3, 32'd5, 32'h0000_1234);
    bus32.A     = 32'd9;
    bus32.B     = 32'd3;
    bus32.ALUOp = ALU_DIV;
    bus32.start = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    bus32.A     = 32'hDEAD_BEEF;
    bus32.B     = 32'h1234_5678;
    check("busy_after_ignored_start", 64'(bus32.busy), 64'd1);
    wait_idle("mult_3_5");

    // Back-to-back: a second start presented during the DONE cycle.
    issue32("b2b_mult", ALU_MULT, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1);
    n = 0;
    while (!bus32.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", 64'(bus32.done), 64'd1);
    issue32("b2b_div", ALU_DIV, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1);
    check("b2b_busy_reasserts", 64'(bus32.busy), 64'd1);
    wait_idle("b2b_div");

    bus32.ALUOp = ALU_ADD;
    bus32.start = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    check("start_non_mdu_ignored", 64'(bus32.busy), 64'd0);

    issue8("w8_mult_200_200", ALU_MULT, 8'd200, 8'd200, 8'h9C, 8'h40);
    wait_idle("w8_mult");
    issue8("w8_div_255_16", ALU_DIV, 8'd255, 8'd16, 8'd15, 8'd15);
    wait_idle("w8_div");

    // Abort a MULT at RUN cycle 16 with reset asserted mid-cycle.
    issue32("abort_mult", ALU_MULT, 32'd7, 32'd9, 32'd0, 32'd0, 0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    check("abort_busy_before", 64'(bus32.busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(bus32.busy), 64'd0);
    check("abort_done", 64'(bus32.done), 64'd0);
    check("abort_hi",   64'(bus32.HI),   64'd0);
    check("abort_lo",   64'(bus32.LO),   64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (45) @(negedge clk);
    check("post_abort_busy", 64'(bus32.busy), 64'd0);
    check("post_abort_hi",   64'(bus32.HI),   64'd0);
    check("queues_drained",  64'(q32.size() + q8.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
